// File: rtl/adiabatic_pclk_sequencer.sv
// Four-phase trapezoidal power-clock sequencer for adiabatic pipeline stages.
// Stage i runs one quarter behind stage i-1; start and drain are staggered so no stage is cut mid-ramp.
module adiabatic_pclk_sequencer #(
   parameter int NUM_STAGES     = 4,
   parameter int QUARTER_CYCLES = 4,
   parameter int CNT_W          = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   output logic [NUM_STAGES-1:0] clkpos,
   output logic [NUM_STAGES-1:0] clkneg,
   output logic [NUM_STAGES-1:0] ramp_up,
   output logic [NUM_STAGES-1:0] ramp_dn,
   output logic [NUM_STAGES-1:0] stage_active,
   output logic                  busy,
   output logic                  period_done,
   output logic [CNT_W-1:0]      period_cnt
);

   localparam int TICK_W = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(QUARTER_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [TICK_W-1:0]     tick, tick_nxt;
   logic [1:0]            q, q_nxt, q_inc;
   logic [NUM_STAGES-1:0] active, active_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  done, done_nxt;
   logic                  boundary;

   // Quarter seen by stage i: 0=EVAL, 1=HOLD, 2=RECOVER, 3=WAIT.
   function automatic logic [1:0] stage_q(input logic [1:0] gq, input int i);
      return gq - 2'(i % 4);
   endfunction

   assign boundary = (tick == TICK_LAST);
   assign q_inc    = q + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         tick   <= '0;
         q      <= '0;
         active <= '0;
         cnt    <= '0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         tick   <= tick_nxt;
         q      <= q_nxt;
         active <= active_nxt;
         cnt    <= cnt_nxt;
         done   <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      tick_nxt   = tick;
      q_nxt      = q;
      active_nxt = active;
      cnt_nxt    = cnt;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            tick_nxt = '0;
            q_nxt    = '0;
            if (en) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
               for (int i = 0; i < NUM_STAGES; i++) begin
                  active_nxt[i] = ((i % 4) == 0);
               end
            end
         end
         RUN, DRAIN: begin
            if (boundary) begin
               tick_nxt = '0;
               q_nxt    = q_inc;
               if (q == 2'd3) begin
                  done_nxt = 1'b1;
                  cnt_nxt  = cnt + CNT_W'(1);
               end
               // Join only at the start of EVAL; park only once RECOVER is finished.
               for (int i = 0; i < NUM_STAGES; i++) begin
                  if (state == RUN && en && !active[i] && stage_q(q_inc, i) == 2'd0) begin
                     active_nxt[i] = 1'b1;
                  end
                  if (state == DRAIN && active[i] && stage_q(q_inc, i) == 2'd3) begin
                     active_nxt[i] = 1'b0;
                  end
               end
            end else begin
               tick_nxt = tick + TICK_W'(1);
            end
            if (state == RUN) begin
               if (!en) begin
                  state_nxt = DRAIN;
               end
            end else if (en) begin
               state_nxt = RUN;
            end else if (active == '0) begin
               state_nxt = IDLE;
               tick_nxt  = '0;
               q_nxt     = '0;
            end
         end
         default: begin
            state_nxt  = IDLE;
            tick_nxt   = '0;
            q_nxt      = '0;
            active_nxt = '0;
         end
      endcase
   end

   always_comb begin
      ramp_up = '0;
      clkpos  = '0;
      ramp_dn = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         ramp_up[i] = active[i] && (stage_q(q, i) == 2'd0);
         clkpos[i]  = active[i] && (stage_q(q, i) == 2'd1);
         ramp_dn[i] = active[i] && (stage_q(q, i) == 2'd2);
      end
   end

   assign clkneg       = ~clkpos;
   assign stage_active = active;
   assign busy         = (state != IDLE);
   assign period_done  = done;
   assign period_cnt   = cnt;

endmodule

// File: tb/tb_adiabatic_pclk_sequencer.sv
// Directed bench for adiabatic_pclk_sequencer with QUARTER_CYCLES=2 and four stages.
module tb_adiabatic_pclk_sequencer;

   localparam int NS = 4;
   localparam int QC = 2;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          clk_run = 1'b1;
   logic          rst_n;
   logic          en;
   logic [NS-1:0] clkpos, clkneg, ramp_up, ramp_dn, stage_active;
   logic          busy, period_done;
   logic [CW-1:0] period_cnt;

   int npass  = 0;
   int nfail  = 0;
   int ntotal = 0;
   int rc     = 0;

   // {stage_active, ramp_up, clkpos, ramp_dn}, indexed by global quarter.
   logic [15:0] start_t  [4] = '{16'b0001_0001_0000_0000, 16'b0011_0010_0001_0000,
                                 16'b0111_0100_0010_0001, 16'b1111_1000_0100_0010};
   logic [15:0] steady_t [4] = '{16'b1111_0001_1000_0100, 16'b1111_0010_0001_1000,
                                 16'b1111_0100_0010_0001, 16'b1111_1000_0100_0010};

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   adiabatic_pclk_sequencer #(
      .NUM_STAGES(NS),
      .QUARTER_CYCLES(QC),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .clkpos(clkpos),
      .clkneg(clkneg),
      .ramp_up(ramp_up),
      .ramp_dn(ramp_dn),
      .stage_active(stage_active),
      .busy(busy),
      .period_done(period_done),
      .period_cnt(period_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ntotal++;
      assert (obs === expv) npass++;
      else begin
         nfail++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, rc, obs, expv);
      end
   endtask

   task automatic obs_cycle(input logic b, input logic [15:0] o, input logic d, input int c);
      chk("outs", {16'b0, stage_active, ramp_up, clkpos, ramp_dn}, {16'b0, o});
      chk("clkneg", {28'b0, clkneg}, {28'b0, ~clkpos});
      chk("busy", {31'b0, busy}, {31'b0, b});
      chk("period_done", {31'b0, period_done}, {31'b0, d});
      chk("period_cnt", {16'b0, period_cnt}, c);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_clkpos"}, {28'b0, clkpos}, 32'h0);
      chk({tag, "_clkneg"}, {28'b0, clkneg}, 32'hF);
      chk({tag, "_ramp"}, {24'b0, ramp_up, ramp_dn}, 32'h0);
      chk({tag, "_active"}, {28'b0, stage_active}, 32'h0);
      chk({tag, "_busy_done"}, {30'b0, busy, period_done}, 32'h0);
      chk({tag, "_cnt"}, {16'b0, period_cnt}, 32'h0);
   endtask

   // Run from a fresh start: cycle r follows the r-th edge after en is first sampled.
   task automatic run_check(input int from, input int to);
      for (int r = from; r <= to; r++) begin
         int qq;
         @(negedge clk);
         rc = r;
         qq = ((r - 1) / QC) % 4;
         obs_cycle(1'b1, (r <= 8) ? start_t[qq] : steady_t[qq],
                   (r >= 9) && ((r - 1) % 8 == 0), (r < 9) ? 0 : (r - 1) / 8);
         chk("onehot_eval", $countones(ramp_up), 1);
      end
   endtask

   task automatic step_obs(input int r, input logic b, input logic [15:0] o, input logic d, input int c);
      @(negedge clk);
      rc = r;
      obs_cycle(b, o, d, c);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      #12;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step_obs(0, 1'b0, 16'h0, 1'b0, 0);
      step_obs(0, 1'b0, 16'h0, 1'b0, 0);

      // start, steady run, then drop en mid-HOLD of stage 0
      en = 1'b1;
      run_check(1, 43);
      en = 1'b0;
      step_obs(44, 1'b1, 16'b1111_0010_0001_1000, 1'b0, 5);
      step_obs(45, 1'b1, 16'b0111_0100_0010_0001, 1'b0, 5);
      step_obs(46, 1'b1, 16'b0111_0100_0010_0001, 1'b0, 5);
      step_obs(47, 1'b1, 16'b0110_0000_0100_0010, 1'b0, 5);
      step_obs(48, 1'b1, 16'b0110_0000_0100_0010, 1'b0, 5);
      step_obs(49, 1'b1, 16'b0100_0000_0000_0100, 1'b1, 6);
      step_obs(50, 1'b1, 16'b0100_0000_0000_0100, 1'b0, 6);
      step_obs(51, 1'b1, 16'b0000_0000_0000_0000, 1'b0, 6);
      step_obs(52, 1'b0, 16'b0000_0000_0000_0000, 1'b0, 6);

      // restart from IDLE, drain again, re-enable with three stages still active
      en = 1'b1;
      run_check(1, 43);
      en = 1'b0;
      step_obs(44, 1'b1, 16'b1111_0010_0001_1000, 1'b0, 5);
      step_obs(45, 1'b1, 16'b0111_0100_0010_0001, 1'b0, 5);
      en = 1'b1;
      step_obs(46, 1'b1, 16'b0111_0100_0010_0001, 1'b0, 5);
      run_check(47, 54);

      // stop the clock while stage 2 is ramping up, then reset asynchronously
      clk_run = 1'b0;
      chk("pre_reset_ramp_up2", {31'b0, ramp_up[2]}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async_reset");
      #5;
      rst_n = 1'b1;
      #3;
      chk_reset("released");
      clk_run = 1'b1;
      run_check(1, 12);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
